uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
Command-frame controller sitting directly behind the UART receive block.
- Consumes the receiver's byte-done level and byte data.
- Sequences received bytes through a fixed 5-byte frame: header, addr, data_hi, data_lo, checksum.
- Issues a single-cycle register-write command to the board control logic on a valid frame.
- Flags checksum errors and inter-byte timeouts, and keeps a saturating error count for diagnostics.

Parameters:
HEADER, 8'h55, frame start byte.
TIMEOUT_CYC, 250000, sys_clk cycles allowed between bytes inside a frame (5 ms at 50 MHz); must be >= 2.
TO_W, 18, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
rx_done  in  1  receiver byte-done level; may remain high for many cycles per byte
rx_data  in  8  received byte, valid while rx_done high
cmd_valid  out  1  one-cycle pulse: cmd_addr/cmd_data valid
cmd_addr  out  8  command address, held until next cmd_valid
cmd_data  out  16  command data {data_hi,data_lo}, held until next cmd_valid
err_chk  out  1  one-cycle pulse: checksum mismatch
err_timeout  out  1  one-cycle pulse: inter-byte timeout
err_cnt  out  8  saturating count of err_chk + err_timeout events
busy  out  1  high whenever state != IDLE

Behaviour:
Clock and reset:
- One clock: sys_clk.
- Reset is synchronous, active-high: sys_rst sampled on the sys_clk rising edge.

Reset values:
- cmd_valid, err_chk, err_timeout, busy = 0; cmd_addr = 0; cmd_data = 0; err_cnt = 0.
- state = IDLE; timeout counter = 0.
- rx_done delay register = 1, so a done level present at reset release is not taken as a byte.
- Reset mid-frame discards the partial frame; no error pulse is generated.

Byte accept:
- byte_evt = rx_done & ~rx_done_d. Exactly one byte per rising edge of rx_done, however long the level lasts.
- rx_data is sampled in the byte_evt cycle.

State machine (state register updates at the end of the byte_evt cycle):
- IDLE: byte == HEADER -> S_ADDR; any other byte is ignored, no error.
- S_ADDR: latch addr -> S_DHI.
- S_DHI: latch data_hi -> S_DLO.
- S_DLO: latch data_lo -> S_CHK.
- S_CHK: compare byte with (addr + data_hi + data_lo) mod 256 (8-bit wrap; header excluded), then return to IDLE.
  - Match: cmd_valid = 1 for exactly one cycle, in the cycle after byte_evt; cmd_addr/cmd_data update in that same cycle.
  - Mismatch: err_chk pulses in the same relative cycle; cmd_addr/cmd_data unchanged.
- A HEADER value received in S_ADDR..S_CHK is treated as ordinary data (no resync).

Timeout:
- Counter clears on every byte_evt and while in IDLE; it increments each cycle in any other state.
- When the counter equals TIMEOUT_CYC-1 with no byte_evt: go to IDLE and pulse err_timeout in the next cycle.
- byte_evt in the same cycle as expiry: the byte wins (counter cleared, byte processed, no timeout).

Error counter:
- err_cnt increments by 1 on each err_chk or err_timeout pulse (the two cannot coincide) and saturates at 8'hFF.

Latency:
- From the checksum byte's rx_done rising edge (sampled) to cmd_valid: 1 cycle.
- Back-to-back frames are accepted with no gap beyond the receiver's own byte timing.

Test Plan:
1. Valid frame: bytes 55,12,AB,CD,8A -> one cmd_valid, cmd_addr=12, cmd_data=ABCD, err_cnt=0, busy low afterwards.
2. Bad checksum: 55,12,AB,CD,8B -> err_chk one pulse, no cmd_valid, cmd_addr/cmd_data keep their previous values, err_cnt=1.
3. Long done level plus garbage: rx_done held high 2600 cycles per byte, preceded by stray bytes 00,FF,AA in IDLE -> each frame byte counted once, strays ignored, frame 55,01,00,02,03 gives cmd_addr=01, cmd_data=0002.
4. Timeout: with TIMEOUT_CYC=100, send 55,12 then silence -> err_timeout exactly 100 cycles after the 12 byte_evt, busy drops; then send 55,01,00,02,03 -> accepted normally.
5. Boundary: with TIMEOUT_CYC=100, a byte_evt at counter 99 -> no timeout, frame continues. Also, checksum wrap with 55,FF,FF,FF,FD -> cmd_data=FFFF.
6. Reset: sys_rst asserted after 55,12,AB, released with rx_done high -> no byte taken until the next rising edge, all outputs zero, no error pulses; 256+ error frames -> err_cnt holds FF.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Command-frame controller that sits directly behind a UART receiver. Each
// rising edge of the receiver's byte-done level is taken as exactly one byte.
// Bytes are sequenced through a fixed 5-byte frame:
//
//   HEADER, addr, data_hi, data_lo, checksum
//
// The checksum is (addr + data_hi + data_lo) mod 256. The header is not part of
// the sum. A good frame produces a one-cycle cmd_valid pulse together with
// updated cmd_addr/cmd_data. A bad checksum produces a one-cycle err_chk pulse.
// If the gap between bytes inside a frame grows too long, the frame is dropped
// and a one-cycle err_timeout pulse is produced. Both error kinds feed a
// saturating 8-bit diagnostic counter.
//
// Parameters:
//   HEADER      - frame start byte
//   TIMEOUT_CYC - sys_clk cycles allowed between bytes inside a frame (>= 2)
//   TO_W        - timeout counter width, 2**TO_W > TIMEOUT_CYC
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst      in   synchronous reset, active-high
//   rx_done      in   receiver byte-done level (may stay high many cycles)
//   rx_data[7:0] in   received byte, valid while rx_done is high
//   cmd_valid    out  one-cycle pulse, cmd_addr/cmd_data valid
//   cmd_addr     out  command address, held until the next cmd_valid
//   cmd_data     out  {data_hi, data_lo}, held until the next cmd_valid
//   err_chk      out  one-cycle pulse on checksum mismatch
//   err_timeout  out  one-cycle pulse on inter-byte timeout
//   err_cnt      out  saturating count of err_chk + err_timeout events
//   busy         out  high whenever a frame is in progress
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter logic [7:0] HEADER      = 8'h55,
  parameter int         TIMEOUT_CYC = 250000,
  parameter int         TO_W        = 18
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        err_chk,
  output logic        err_timeout,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  state_t            state_reg;
  logic              rx_done_d_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic [7:0]        addr_reg;
  logic [7:0]        dhi_reg;
  logic [7:0]        dlo_reg;
  logic              cmd_valid_reg;
  logic [7:0]        cmd_addr_reg;
  logic [15:0]       cmd_data_reg;
  logic              err_chk_reg;
  logic              err_timeout_reg;
  logic [7:0]        err_cnt_reg;

  logic              byte_evt;
  logic              to_expire;
  logic [7:0]        sum_next;
  logic [7:0]        err_cnt_next;

  // One byte per rising edge of rx_done, however long the level is held.
  assign byte_evt = rx_done & ~rx_done_d_reg;

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign to_expire = (state_reg != IDLE) && !byte_evt && (to_cnt_reg == TO_LAST);

  assign sum_next     = addr_reg + dhi_reg + dlo_reg;
  assign err_cnt_next = (err_cnt_reg == 8'hFF) ? 8'hFF : err_cnt_reg + 8'd1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg       <= IDLE;
      // Held at 1 so a done level already present at reset release is not
      // mistaken for a fresh byte.
      rx_done_d_reg   <= 1'b1;
      to_cnt_reg      <= '0;
      addr_reg        <= 8'h00;
      dhi_reg         <= 8'h00;
      dlo_reg         <= 8'h00;
      cmd_valid_reg   <= 1'b0;
      cmd_addr_reg    <= 8'h00;
      cmd_data_reg    <= 16'h0000;
      err_chk_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_cnt_reg     <= 8'h00;
    end else begin
      rx_done_d_reg   <= rx_done;
      cmd_valid_reg   <= 1'b0;
      err_chk_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;

      if (byte_evt || state_reg == IDLE) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + TO_ONE;
      end

      if (to_expire) begin
        state_reg       <= IDLE;
        err_timeout_reg <= 1'b1;
        err_cnt_reg     <= err_cnt_next;
      end else if (byte_evt) begin
        case (state_reg)
          IDLE: begin
            // Non-header bytes outside a frame are silently dropped.
            if (rx_data == HEADER) begin
              state_reg <= S_ADDR;
            end
          end
          S_ADDR: begin
            addr_reg  <= rx_data;
            state_reg <= S_DHI;
          end
          S_DHI: begin
            dhi_reg   <= rx_data;
            state_reg <= S_DLO;
          end
          S_DLO: begin
            dlo_reg   <= rx_data;
            state_reg <= S_CHK;
          end
          S_CHK: begin
            state_reg <= IDLE;
            if (rx_data == sum_next) begin
              cmd_valid_reg <= 1'b1;
              cmd_addr_reg  <= addr_reg;
              cmd_data_reg  <= {dhi_reg, dlo_reg};
            end else begin
              err_chk_reg <= 1'b1;
              err_cnt_reg <= err_cnt_next;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_valid   = cmd_valid_reg;
  assign cmd_addr    = cmd_addr_reg;
  assign cmd_data    = cmd_data_reg;
  assign err_chk     = err_chk_reg;
  assign err_timeout = err_timeout_reg;
  assign err_cnt     = err_cnt_reg;
  assign busy        = (state_reg != IDLE);

endmodule
